// File: rtl/fetch_ctrl_if.sv
// SRAM-like instruction bus between the fetch controller (master) and instruction memory (slave).
interface fetch_ctrl_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, keeps one request outstanding on the
// instruction bus and holds the returned word for decode, applying branch and exception redirects.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall_i,
  input  logic         branch_flag_i,
  input  logic [31:0]  branch_target_address_i,
  input  logic         exc_flag_i,
  input  logic [31:0]  exc_target_i,
  fetch_ctrl_if.master bus,
  output logic         inst_valid_o,
  output logic [31:0]  inst_o,
  output logic [31:0]  inst_pc_o
);

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        br_pend_q, br_pend_d;
  logic [31:0] br_tgt_q, br_tgt_d;
  logic [31:0] br_slot_q, br_slot_d;

  logic        consume;
  logic        accept;
  logic [31:0] slot_pc;

  assign consume = valid_q && !stall_i;
  assign slot_pc = inst_pc_q + 32'd4;

  // A new request only goes out when the buffer it will land in is free by the time data returns.
  assign bus.inst_req  = rst && (state_q == S_REQ) && (!valid_q || !stall_i);
  assign bus.inst_addr = pc_q;
  assign accept        = bus.inst_req && bus.inst_addr_ok;

  assign inst_valid_o = valid_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    valid_d   = valid_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    br_pend_d = br_pend_q;
    br_tgt_d  = br_tgt_q;
    br_slot_d = br_slot_q;

    if (consume) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      S_REQ: begin
        if (accept) begin
          state_d  = S_WAIT;
          req_pc_d = pc_q;
          if (br_pend_q && (pc_q == br_slot_q)) begin
            pc_d      = br_tgt_q;
            br_pend_d = 1'b0;
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end
      end
      S_WAIT: begin
        if (bus.inst_data_ok) begin
          state_d   = S_REQ;
          valid_d   = 1'b1;
          inst_d    = bus.inst_rdata;
          inst_pc_d = req_pc_q;
        end
      end
      S_DISCARD: begin
        if (bus.inst_data_ok) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    // Delay slot already issued (earlier or in this very cycle): redirect now, nothing to remember.
    if (consume && branch_flag_i) begin
      if ((pc_q == slot_pc + 32'd4) || (accept && (pc_q == slot_pc))) begin
        pc_d = branch_target_address_i;
      end else begin
        br_pend_d = 1'b1;
        br_tgt_d  = branch_target_address_i;
        br_slot_d = slot_pc;
      end
    end

    if (exc_flag_i) begin
      pc_d      = exc_target_i;
      valid_d   = 1'b0;
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;
      br_pend_d = 1'b0;
      unique case (state_q)
        S_REQ:     state_d = accept ? S_DISCARD : S_REQ;
        S_WAIT:    state_d = bus.inst_data_ok ? S_REQ : S_DISCARD;
        S_DISCARD: state_d = bus.inst_data_ok ? S_REQ : S_DISCARD;
        default:   state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      req_pc_q  <= RESET_PC;
      valid_q   <= 1'b0;
      inst_q    <= 32'd0;
      inst_pc_q <= 32'd0;
      br_pend_q <= 1'b0;
      br_tgt_q  <= 32'd0;
      br_slot_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_pc_q  <= req_pc_d;
      valid_q   <= valid_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      br_pend_q <= br_pend_d;
      br_tgt_q  <= br_tgt_d;
      br_slot_q <= br_slot_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: the bench plays instruction memory and decode, and predicts the fetch
// stream from program-order rules (sequential +4, branch after its delay slot).
module tb_fetch_ctrl;
  localparam logic [31:0] RESET_PC = 32'hbfc00000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i = 1'b0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_address_i = 32'd0;
  logic        exc_flag_i = 1'b0;
  logic [31:0] exc_target_i = 32'd0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;

  fetch_ctrl_if bus();

  fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .stall_i                (stall_i),
    .branch_flag_i          (branch_flag_i),
    .branch_target_address_i(branch_target_address_i),
    .exc_flag_i             (exc_flag_i),
    .exc_target_i           (exc_target_i),
    .bus                    (bus),
    .inst_valid_o           (inst_valid_o),
    .inst_o                 (inst_o),
    .inst_pc_o              (inst_pc_o)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  int          cfg_addr_wait, cfg_lat, cfg_stall_pct, cfg_br_pct;
  bit          cfg_rand, cfg_force_br, cfg_stall_win;
  logic [31:0] cfg_br_pc, cfg_br_tgt, cfg_stall_pc;

  logic [31:0] m_next, m_slot, m_tgt, m_last_slot;
  bit          m_pend;
  bit          outst;
  logic [31:0] out_addr;
  int          out_lat, req_age, cur_wait, stall_run;
  bit          exp_valid;
  logic [31:0] exp_pc, exp_inst;
  logic [31:0] acc_log[$];
  int          data_drv, dut_cons;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  task automatic set_cfg(input int aw, input int lat, input int st, input int br, input bit rnd);
    cfg_addr_wait = aw;  cfg_lat = lat;  cfg_stall_pct = st;  cfg_br_pct = br;  cfg_rand = rnd;
    cfg_force_br = 1'b0; cfg_stall_win = 1'b0;
    cfg_br_pc = 32'd0;   cfg_br_tgt = 32'd0;  cfg_stall_pc = 32'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; stall_i = 1'b0; branch_flag_i = 1'b0; exc_flag_i = 1'b0;
    bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_next = RESET_PC; m_pend = 1'b0; m_last_slot = 32'h1;
    outst = 1'b0; out_lat = 0; req_age = 0; cur_wait = cfg_addr_wait; stall_run = 0;
    exp_valid = 1'b0; exp_pc = 32'd0; exp_inst = 32'd0;
    acc_log.delete(); data_drv = 0; dut_cons = 0;
  endtask

  // One iteration per clock, entered at the falling edge.
  task automatic run(input int n);
    logic [31:0] d, tgt;
    bit dok, consume, br, exp_req, aok;
    for (int c = 0; c < n; c++) begin
      checks++;
      if (inst_valid_o !== exp_valid) begin
        errs++; $display("FAIL valid: cycle %0d got %b want %b", c, inst_valid_o, exp_valid);
      end
      if (exp_valid) begin
        checks++;
        if (inst_pc_o !== exp_pc || inst_o !== exp_inst) begin
          errs++; $display("FAIL inst_out: cycle %0d got pc=%h inst=%h want pc=%h inst=%h",
                           c, inst_pc_o, inst_o, exp_pc, exp_inst);
        end
      end
      dok = outst && (out_lat == 0);
      bus.inst_data_ok = dok;
      bus.inst_rdata   = dok ? mem(out_addr) : $urandom;
      if (cfg_stall_win) stall_i = exp_valid && (exp_pc == cfg_stall_pc) && (stall_run < 5);
      else               stall_i = (int'($urandom_range(99)) < cfg_stall_pct);
      if (cfg_stall_win && stall_i) stall_run++;
      consume = exp_valid && !stall_i;
      br  = 1'b0;
      tgt = $urandom & 32'hffff_fffc;
      if (consume && !m_pend && (exp_pc != m_last_slot)) begin
        if (cfg_force_br) begin
          br = (exp_pc == cfg_br_pc); tgt = cfg_br_tgt;
        end else begin
          br = (int'($urandom_range(99)) < cfg_br_pct);
        end
      end
      branch_flag_i = consume ? br : 1'($urandom_range(1));
      branch_target_address_i = tgt;
      exp_req = !outst && (!exp_valid || !stall_i);
      if (exp_req && req_age == 0) cur_wait = cfg_rand ? int'($urandom_range(3)) : cfg_addr_wait;
      aok = exp_req && (req_age >= cur_wait);
      bus.inst_addr_ok = aok;
      #1;
      checks++;
      if (bus.inst_req !== exp_req) begin
        errs++; $display("FAIL req: cycle %0d got %b want %b", c, bus.inst_req, exp_req);
      end
      if (exp_req) begin
        checks++;
        if (bus.inst_addr !== m_next) begin
          errs++; $display("FAIL addr: cycle %0d got %h want %h", c, bus.inst_addr, m_next);
        end
      end
      if (inst_valid_o === 1'b1 && !stall_i) dut_cons++;
      if (br) begin
        d = exp_pc + 32'd4;
        if (m_next == d + 32'd4) m_next = tgt;
        else begin m_pend = 1'b1; m_slot = d; m_tgt = tgt; end
        m_last_slot = d;
      end
      if (aok) begin
        acc_log.push_back(bus.inst_addr);
        outst = 1'b1; out_addr = m_next;
        out_lat = cfg_rand ? int'($urandom_range(3)) : cfg_lat;
        if (m_pend && m_next == m_slot) begin m_next = m_tgt; m_pend = 1'b0; end
        else m_next = m_next + 32'd4;
        req_age = 0;
      end else if (exp_req) req_age++;
      else req_age = 0;
      if (dok) begin
        outst = 1'b0; data_drv++;
        exp_valid = 1'b1; exp_pc = out_addr; exp_inst = mem(out_addr);
      end else if (consume) exp_valid = 1'b0;
      if (outst && !aok && !dok && out_lat > 0) out_lat--;
      @(negedge clk);
    end
    branch_flag_i = 1'b0; stall_i = 1'b0; bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.inst_req !== 1'b0 || bus.inst_addr !== RESET_PC) begin
      errs++; $display("FAIL reset_bus: got req=%b addr=%h want req=0 addr=%h", bus.inst_req, bus.inst_addr, RESET_PC);
    end
    checks++;
    if (inst_valid_o !== 1'b0 || inst_o !== 32'd0 || inst_pc_o !== 32'd0) begin
      errs++; $display("FAIL reset_out: got valid=%b inst=%h pc=%h want 0/0/0", inst_valid_o, inst_o, inst_pc_o);
    end
    rst = 1'b1; #1;
    checks++;
    if (bus.inst_req !== 1'b1 || bus.inst_addr !== RESET_PC) begin
      errs++; $display("FAIL first_req: got req=%b addr=%h want req=1 addr=%h", bus.inst_req, bus.inst_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    set_cfg(0, 0, 0, 0, 1'b0);
    do_reset();
    run(12);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (acc_log.size() <= k || acc_log[k] !== RESET_PC + 32'(4 * k)) begin
        errs++; $display("FAIL stream_addr%0d: got %h want %h", k,
                         (acc_log.size() > k) ? acc_log[k] : 32'hx, RESET_PC + 32'(4 * k));
      end
    end
    checks++;
    if (dut_cons != 5) begin
      errs++; $display("FAIL stream_rate: got %0d deliveries in 12 cycles want 5", dut_cons);
    end
  endtask

  task automatic branch_case(input string nm, input int aw, input int ncyc,
                             input logic [31:0] bpc, input logic [31:0] btgt);
    int idx;
    set_cfg(aw, 0, 0, 0, 1'b0);
    cfg_force_br = 1'b1; cfg_br_pc = bpc; cfg_br_tgt = btgt;
    do_reset();
    run(ncyc);
    idx = -1;
    foreach (acc_log[k]) if (idx < 0 && acc_log[k] == bpc) idx = k;
    checks++;
    if (idx < 0 || idx + 3 >= acc_log.size()) begin
      errs++; $display("FAIL %s_found: branch pc %h not followed by 3 fetches (log size %0d)", nm, bpc, acc_log.size());
    end else begin
      checks++;
      if (acc_log[idx+1] !== bpc + 32'd4 || acc_log[idx+2] !== btgt || acc_log[idx+3] !== btgt + 32'd4) begin
        errs++; $display("FAIL %s_order: got %h %h %h want %h %h %h", nm, acc_log[idx+1], acc_log[idx+2],
                         acc_log[idx+3], bpc + 32'd4, btgt, btgt + 32'd4);
      end
    end
  endtask

  task automatic test_branch();
    branch_case("br_same_cycle", 0, 24, 32'hbfc00010, 32'hbfc00100);
    branch_case("br_pending",    2, 44, 32'hbfc00010, 32'hbfc00100);
    branch_case("br_wrap",       0, 24, 32'hbfc00004, 32'hfffffff8);
  endtask

  task automatic test_stall();
    int idx;
    set_cfg(0, 0, 0, 0, 1'b0);
    cfg_stall_win = 1'b1; cfg_stall_pc = 32'hbfc00008;
    do_reset();
    run(30);
    idx = -1;
    foreach (acc_log[k]) if (idx < 0 && acc_log[k] == 32'hbfc00008) idx = k;
    checks++;
    if (idx < 0 || idx + 1 >= acc_log.size() || acc_log[idx+1] !== 32'hbfc0000c) begin
      errs++; $display("FAIL stall_resume: fetch after bfc00008 missing or wrong (idx %0d size %0d)", idx, acc_log.size());
    end
    checks++;
    if (dut_cons + int'(exp_valid) != data_drv) begin
      errs++; $display("FAIL stall_count: got %0d consumed want %0d", dut_cons, data_drv - int'(exp_valid));
    end
  endtask

  task automatic test_delayed();
    set_cfg(3, 4, 0, 0, 1'b0);
    do_reset();
    run(60);
    foreach (acc_log[k]) begin
      checks++;
      if (acc_log[k] !== RESET_PC + 32'(4 * k)) begin
        errs++; $display("FAIL delayed_addr%0d: got %h want %h", k, acc_log[k], RESET_PC + 32'(4 * k));
      end
    end
    checks++;
    if (dut_cons + int'(exp_valid) != data_drv) begin
      errs++; $display("FAIL delayed_count: got %0d consumed want %0d", dut_cons, data_drv - int'(exp_valid));
    end
  endtask

  task automatic test_random();
    set_cfg(0, 0, 30, 15, 1'b1);
    do_reset();
    run(3000);
    checks++;
    if (dut_cons + int'(exp_valid) != data_drv) begin
      errs++; $display("FAIL random_count: got %0d consumed want %0d", dut_cons, data_drv - int'(exp_valid));
    end
  endtask

  task automatic test_exception();
    set_cfg(0, 0, 0, 0, 1'b0);
    do_reset();
    bus.inst_addr_ok = 1'b1;
    @(negedge clk);
    // in WAIT: redirect before the data returns
    bus.inst_addr_ok = 1'b0; exc_flag_i = 1'b1; exc_target_i = 32'hbfc00380; #1;
    checks++;
    if (bus.inst_req !== 1'b0) begin
      errs++; $display("FAIL exc_wait_req: got %b want 0", bus.inst_req);
    end
    @(negedge clk);
    exc_flag_i = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'hdeadbeef;
    @(negedge clk);
    bus.inst_data_ok = 1'b0; #1;
    checks++;
    if (inst_valid_o !== 1'b0) begin
      errs++; $display("FAIL exc_discard: got valid=%b want 0", inst_valid_o);
    end
    checks++;
    if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hbfc00380) begin
      errs++; $display("FAIL exc_redirect: got req=%b addr=%h want 1 bfc00380", bus.inst_req, bus.inst_addr);
    end
    bus.inst_addr_ok = 1'b1;
    @(negedge clk);
    bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = mem(32'hbfc00380);
    @(negedge clk);
    bus.inst_data_ok = 1'b0;
    checks++;
    if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'hbfc00380 || inst_o !== mem(32'hbfc00380)) begin
      errs++; $display("FAIL exc_target_inst: got v=%b pc=%h inst=%h want 1 bfc00380 %h",
                       inst_valid_o, inst_pc_o, inst_o, mem(32'hbfc00380));
    end
    // consume a taken branch, accept the next address and take an exception all at once
    branch_flag_i = 1'b1; branch_target_address_i = 32'hbfc00100;
    exc_flag_i = 1'b1; exc_target_i = 32'hbfc00500; bus.inst_addr_ok = 1'b1;
    @(negedge clk);
    branch_flag_i = 1'b0; exc_flag_i = 1'b0; bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'hbad0bad0; #1;
    checks++;
    if (inst_valid_o !== 1'b0 || bus.inst_req !== 1'b0) begin
      errs++; $display("FAIL exc_br_discard: got valid=%b req=%b want 0 0", inst_valid_o, bus.inst_req);
    end
    @(negedge clk);
    bus.inst_data_ok = 1'b0; #1;
    checks++;
    if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hbfc00500 || inst_valid_o !== 1'b0) begin
      errs++; $display("FAIL exc_br_redirect: got req=%b addr=%h v=%b want 1 bfc00500 0",
                       bus.inst_req, bus.inst_addr, inst_valid_o);
    end
    bus.inst_addr_ok = 1'b1;
    @(negedge clk);
    bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = mem(32'hbfc00500);
    @(negedge clk);
    bus.inst_data_ok = 1'b0; #1;
    checks++;
    if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'hbfc00500) begin
      errs++; $display("FAIL exc_br_inst: got v=%b pc=%h want 1 bfc00500", inst_valid_o, inst_pc_o);
    end
    checks++;
    if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hbfc00504) begin
      errs++; $display("FAIL exc_no_branch: got req=%b addr=%h want 1 bfc00504", bus.inst_req, bus.inst_addr);
    end
  endtask

  task automatic test_rst_mid();
    set_cfg(0, 0, 0, 0, 1'b0);
    do_reset();
    bus.inst_addr_ok = 1'b1;
    @(negedge clk);
    bus.inst_addr_ok = 1'b0; #1;
    checks++;
    if (bus.inst_addr !== 32'hbfc00004 || bus.inst_req !== 1'b0) begin
      errs++; $display("FAIL rst_mid_pre: got addr=%h req=%b want bfc00004 0", bus.inst_addr, bus.inst_req);
    end
    #1 rst = 1'b0; #1;
    checks++;
    if (bus.inst_req !== 1'b0 || bus.inst_addr !== RESET_PC || inst_valid_o !== 1'b0) begin
      errs++; $display("FAIL rst_mid_async: got req=%b addr=%h v=%b want 0 %h 0",
                       bus.inst_req, bus.inst_addr, inst_valid_o, RESET_PC);
    end
    @(negedge clk);
    rst = 1'b1; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'hfeedface; #1;
    checks++;
    if (bus.inst_req !== 1'b1 || bus.inst_addr !== RESET_PC) begin
      errs++; $display("FAIL rst_mid_first: got req=%b addr=%h want 1 %h", bus.inst_req, bus.inst_addr, RESET_PC);
    end
    @(negedge clk);
    bus.inst_data_ok = 1'b0; #1;
    checks++;
    if (inst_valid_o !== 1'b0 || bus.inst_req !== 1'b1 || bus.inst_addr !== RESET_PC) begin
      errs++; $display("FAIL rst_mid_stray: got v=%b req=%b addr=%h want 0 1 %h",
                       inst_valid_o, bus.inst_req, bus.inst_addr, RESET_PC);
    end
    bus.inst_addr_ok = 1'b1;
    @(negedge clk);
    bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = mem(RESET_PC);
    @(negedge clk);
    bus.inst_data_ok = 1'b0;
    checks++;
    if (inst_valid_o !== 1'b1 || inst_pc_o !== RESET_PC || inst_o !== mem(RESET_PC)) begin
      errs++; $display("FAIL rst_mid_fetch: got v=%b pc=%h inst=%h want 1 %h %h",
                       inst_valid_o, inst_pc_o, inst_o, RESET_PC, mem(RESET_PC));
    end
  endtask

  initial begin
    bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = 32'd0;
    set_cfg(0, 0, 0, 0, 1'b0);
    test_reset();
    test_stream();
    test_branch();
    test_stall();
    test_delayed();
    test_exception();
    test_rst_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errs, checks);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller for the MIPS core. It owns the fetch PC, sequences it onto the SRAM-like instruction bus and holds the returned instruction for decode. It applies branch redirects after the delay slot and exception/ERET redirects immediately. It replaces the free-running PC register as the front of the IF stage, sitting between instruction memory and the IF/ID boundary.

## Interface
- RESET_PC, 32'hbfc00000, first fetch address after reset
- clk  input  1  clock, all state on posedge
- rst  input  1  reset, asynchronous, active-low
- stall_i  input  1  decode cannot accept; the held instruction stays on the outputs
- branch_flag_i  input  1  decoded instruction (inst_pc_o) is a taken branch/jump; sampled only when consumed
- branch_target_address_i  input  32  branch destination
- exc_flag_i  input  1  flush and redirect (exception entry or ERET), one-cycle pulse
- exc_target_i  input  32  redirect address for exc_flag_i
- inst_req  output  1  bus request
- inst_addr  output  32  request address, equals internal pc
- inst_addr_ok  input  1  address accepted this cycle
- inst_data_ok  input  1  read data valid this cycle
- inst_rdata  input  32  read data
- inst_valid_o  output  1  inst_o/inst_pc_o hold a valid instruction
- inst_o  output  32  instruction to decode
- inst_pc_o  output  32  address of inst_o

## Operation
- One outstanding bus transaction. Word-aligned addresses; pc increments by 4 with 32-bit wrap (32'hfffffffc -> 0).
- States:
  - REQ: inst_req=1 only if the output buffer is empty or consumed this cycle (inst_valid_o && !stall_i). On inst_addr_ok go to WAIT; latch the request address as req_pc; pc <= next address.
  - WAIT: inst_req=0. On inst_data_ok write inst_o<=inst_rdata, inst_pc_o<=req_pc, inst_valid_o<=1; go to REQ.
  - DISCARD: inst_req=0. On inst_data_ok drop the data and go to REQ.
- Consume: inst_valid_o && !stall_i. inst_valid_o clears unless refilled the same cycle.
- Branch, sampled only on consume with branch_flag_i=1:
  - Record a pending target T and delay-slot address D = inst_pc_o+4.
  - If the request for D has not yet been accepted, it is issued normally. On its acceptance, pc <= T instead of D+4, and the pending state clears.
  - If D was already accepted (pc == D+4), pc <= T immediately and the pending state clears.
  - Only one branch is pending at a time. A branch in a delay slot is undefined.
- Exception (exc_flag_i=1, any state):
  - pc <= exc_target_i; inst_valid_o <= 0; the pending branch is cleared.
  - From WAIT, go to DISCARD. From REQ, go to REQ; an address accepted in that same cycle also goes to DISCARD.
  - Highest priority: it overrides a simultaneous branch, consume or data_ok write. A data_ok in DISCARD together with exc_flag_i returns to REQ with the new pc.
- Reset mid-transaction: all state returns to reset values immediately. Any later stray data_ok is ignored because the block is in REQ.

## Timing
- Reset values: pc=RESET_PC, state REQ, inst_req=0 while rst=0, inst_addr=RESET_PC, inst_valid_o=0, inst_o=0, inst_pc_o=0, pending cleared.
- First cycle with rst=1: inst_req=1, inst_addr=RESET_PC.
- inst_addr and inst_req depend only on registered state plus the consume term; there is no combinational path from inst_addr_ok or inst_data_ok to inst_req.
- Minimum latency: request cycle with addr_ok, then data_ok the next cycle, then inst_valid_o=1 the cycle after data_ok. Peak rate is one instruction per 2 cycles.
- Exception redirect: inst_addr=exc_target_i on the cycle after exc_flag_i when no response is in flight. Otherwise it follows one cycle after the discarded data_ok.
- Outputs are stable while stall_i=1.

## Test plan
- Reset, bus always ready (addr_ok=1, data_ok one cycle later): inst_addr 0xbfc00000, 0xbfc00004, 0xbfc00008; inst_pc_o follows with inst_valid_o every other cycle.
- Branch at 0xbfc00010 to 0xbfc00100, delay slot not yet issued: the fetch order is 0x10, 0x14, 0xbfc00100. Repeat with the 0x14 request already accepted: the next inst_addr is 0xbfc00100 and no 0x18 is requested.
- stall_i held 5 cycles with inst_valid_o=1: inst_o/inst_pc_o are unchanged, no inst_req is issued, and fetch resumes with the correct next pc on release.
- exc_flag_i (target 0xbfc00380) while in WAIT: the returning data is discarded, inst_valid_o stays 0, and the next request is 0xbfc00380. With a simultaneous branch_flag_i, the exception wins and no branch target is fetched.
- addr_ok delayed 3 cycles and data_ok delayed 4 cycles: inst_addr is held steady and exactly one instruction is delivered per transaction.
- rst asserted during WAIT, then released: inst_valid_o=0, the first request is 0xbfc00000, and a late data_ok is ignored.
